// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiply/divide family:
// FSM state encoding and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    // Counter wide enough to hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sign_cond.sv
// Operand sign conditioning: converts to magnitudes in signed mode and
// reports whether the final result must be negated.
module mult_sign_cond #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] abs_x,
    output logic [WIDTH-1:0] abs_y,
    output logic             neg
);

    // The magnitude of the most-negative value wraps to 2^(WIDTH-1), which is
    // still correct when the result is read as unsigned.
    assign abs_x = (signed_mode && x[WIDTH-1]) ? -x : x;
    assign abs_y = (signed_mode && y[WIDTH-1]) ? -y : y;
    assign neg   = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: one WIDTH-bit add per clock, WIDTH iterations,
// unsigned or two's-complement operands with a start/busy/done handshake.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic [2*WIDTH-1:0] Z,
    output logic               busy,
    output logic               done
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mult_state_e        state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic [WIDTH-1:0]   abs_x;
    logic [WIDTH-1:0]   abs_y;
    logic               neg_in;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;

    mult_sign_cond #(
        .WIDTH(WIDTH)
    ) u_sign_cond (
        .x           (X),
        .y           (Y),
        .signed_mode (signed_mode),
        .abs_x       (abs_x),
        .abs_y       (abs_y),
        .neg         (neg_in)
    );

    // Upper half of acc holds the partial product; the lower half starts as
    // the multiplier and is consumed one LSB per iteration as the pair shifts.
    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign acc_step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        z_d     = z_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = CALC;
                    mcand_d = abs_x;
                    acc_d   = {{WIDTH{1'b0}}, abs_y};
                    cnt_d   = '0;
                    neg_d   = neg_in;
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    z_d     = neg_q ? -acc_step : acc_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign Z    = z_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=4 and WIDTH=8, against a
// plain-arithmetic product model.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start4, sm4;
    logic [3:0]  x4, y4;
    logic [7:0]  z4;
    logic        busy4, done4;
    logic        start8, sm8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;
    logic        busy8, done8;

    int checks   = 0;
    int failures = 0;
    int selW     = 4;

    logic        obsBusy, obsDone;
    logic [15:0] obsZ;
    assign obsBusy = (selW == 8) ? busy8 : busy4;
    assign obsDone = (selW == 8) ? done8 : done4;
    assign obsZ    = (selW == 8) ? z8 : {8'h00, z4};

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .X(x4), .Y(y4), .Z(z4), .busy(busy4), .done(done4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .X(x8), .Y(y8), .Z(z8), .busy(busy8), .done(done8)
    );

    // Product of two w-bit operands, reduced to 2w bits.
    function automatic longint refModel(input int w, input bit sm, input longint x, input longint y);
        longint a;
        longint b;
        a = x;
        b = y;
        if (sm && x[w-1]) a = x - (longint'(1) << w);
        if (sm && y[w-1]) b = y - (longint'(1) << w);
        return (a * b) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveOps(input int w, input bit sm, input logic [15:0] x, input logic [15:0] y);
        if (w == 8) begin
            sm8 = sm; x8 = x[7:0]; y8 = y[7:0];
        end else begin
            sm4 = sm; x4 = x[3:0]; y4 = y[3:0];
        end
    endtask

    task automatic setStart(input int w, input bit v);
        if (w == 8) start8 = v;
        else        start4 = v;
    endtask

    // Called at the negedge right after start was sampled; scrambles operands
    // while busy and checks latency, busy length and the result.
    task automatic waitDone(input string tag, input int w, input longint expZ);
        int cycles;
        int busyCnt;
        cycles  = 0;
        busyCnt = 0;
        while (!obsDone && cycles < 3 * w + 4) begin
            if (obsBusy) busyCnt++;
            driveOps(w, 1'($urandom % 2), 16'($urandom), 16'($urandom));
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " latency"}, cycles, w);
        checkOutput({tag, " busy_cycles"}, busyCnt, w);
        checkOutput({tag, " busy_at_done"}, obsBusy, 0);
        checkOutput({tag, " Z"}, obsZ, 32'(expZ));
    endtask

    task automatic applyStimulus(input string tag, input int w, input bit sm, input longint x, input longint y);
        longint xm;
        longint ym;
        xm = x & ((longint'(1) << w) - 1);
        ym = y & ((longint'(1) << w) - 1);
        selW = w;
        @(negedge clk);
        driveOps(w, sm, 16'(xm), 16'(ym));
        setStart(w, 1'b1);
        @(negedge clk);
        setStart(w, 1'b0);
        waitDone(tag, w, refModel(w, sm, xm, ym));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int doneCnt;
        logic [7:0] zAtDone;

        rst = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        driveOps(4, 1'b0, 16'h0, 16'h0);
        driveOps(8, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        checkOutput("rst z4", z4, 0);
        checkOutput("rst busy4", busy4, 0);
        checkOutput("rst done4", done4, 0);
        checkOutput("rst z8", z8, 0);
        checkOutput("rst busy8", busy8, 0);
        checkOutput("rst done8", done8, 0);
        rst = 1'b0;

        applyStimulus("u15x15", 4, 1'b0, 15, 15);
        checkOutput("u15x15 literal", z4, 8'hE1);
        repeat (2) begin
            @(negedge clk);
            checkOutput("hold z", z4, 8'hE1);
            checkOutput("done single", done4, 0);
        end

        applyStimulus("s-3x5", 4, 1'b1, 4'hD, 5);
        checkOutput("s-3x5 literal", z4, 8'hF1);
        applyStimulus("s-8x-8", 4, 1'b1, 4'h8, 4'h8);
        checkOutput("s-8x-8 literal", z4, 8'h40);
        applyStimulus("s-8x7", 4, 1'b1, 4'h8, 7);
        checkOutput("s-8x7 literal", z4, 8'hC8);

        // start while busy is ignored
        selW = 4;
        @(negedge clk);
        driveOps(4, 1'b0, 2, 3);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        driveOps(4, 1'b0, 7, 7);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        doneCnt = 0;
        zAtDone = 8'h00;
        repeat (10) begin
            if (done4) begin
                doneCnt++;
                zAtDone = z4;
            end
            @(negedge clk);
        end
        checkOutput("ignored start done_count", doneCnt, 1);
        checkOutput("ignored start Z", zAtDone, 8'h06);
        checkOutput("ignored start Z held", z4, 8'h06);

        // reset in the second CALC cycle
        @(negedge clk);
        driveOps(4, 1'b0, 9, 9);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst busy", busy4, 0);
        checkOutput("midrst done", done4, 0);
        checkOutput("midrst Z", z4, 0);
        repeat (6) @(negedge clk);
        checkOutput("midrst no result", z4, 0);
        applyStimulus("after rst 1x1", 4, 1'b0, 1, 1);

        // WIDTH=8 with back-to-back start held in the DONE cycle
        applyStimulus("u255x255", 8, 1'b0, 255, 255);
        checkOutput("u255x255 literal", z8, 16'hFE01);
        driveOps(8, 1'b0, 0, 200);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waitDone("b2b 0x200", 8, 0);
        applyStimulus("s-128x-128", 8, 1'b1, 8'h80, 8'h80);
        checkOutput("s-128x-128 literal", z8, 16'h4000);

        for (int sm = 0; sm < 2; sm++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    applyStimulus($sformatf("sweep m%0d %0dx%0d", sm, x, y), 4, 1'(sm), x, y);
                end
            end
        end

        repeat (40) begin
            applyStimulus("rand8", 8, 1'($urandom % 2), longint'($urandom % 256), longint'($urandom % 256));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
